// File: rtl/wptr_full_level.sv
// Write-domain pointer and status block for a dual-clock FIFO: binary/Gray write
// pointers plus full, almost-full, fill level and a sticky overflow flag.
module wptr_full_level #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic                wovf_clr,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AFULL_LEVEL = (ADDRSIZE+1)'(DEPTH - AFULL_MARGIN);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic              push;
  logic              full_next;

  assign push       = winc & ~wfull;
  assign wbinnext   = wbin + (ADDRSIZE+1)'(push);
  assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
  assign level_next = wbinnext - rbin_s;
  // Full when the next write pointer has lapped the read pointer exactly once.
  assign full_next  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
  assign waddr      = wbin[ADDRSIZE-1:0];

  always_comb begin
    rbin_s = '0;
    rbin_s[ADDRSIZE] = wq2_rptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= full_next;
      walmost_full <= (level_next >= AFULL_LEVEL);
      wlevel       <= level_next;
      // A dropped write outranks a clear in the same cycle.
      if (winc && wfull)
        woverflow <= 1'b1;
      else if (wovf_clr)
        woverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed self-checking bench for wptr_full_level with ADDRSIZE=4, AFULL_MARGIN=2.
module tb_wptr_full_level;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic       wovf_clr;
  logic [4:0] wq2_rptr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       winc;
    logic       clr;
    logic [4:0] rptr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
  } vec_t;

  vec_t vecs[22];

  wptr_full_level #(.ADDRSIZE(4), .AFULL_MARGIN(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wovf_clr(wovf_clr),
    .wq2_rptr(wq2_rptr), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_addr, input logic [4:0] e_ptr,
                             input logic e_full, input logic e_afull, input logic [4:0] e_level,
                             input logic e_ovf);
    check({tag, ".waddr"}, 32'(waddr), 32'(e_addr));
    check({tag, ".wptr"}, 32'(wptr), 32'(e_ptr));
    check({tag, ".wfull"}, 32'(wfull), 32'(e_full));
    check({tag, ".walmost_full"}, 32'(walmost_full), 32'(e_afull));
    check({tag, ".wlevel"}, 32'(wlevel), 32'(e_level));
    check({tag, ".woverflow"}, 32'(woverflow), 32'(e_ovf));
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the following edge.
  task automatic applyStimulus(input logic inc, input logic clr, input logic [4:0] rptr);
    winc     = inc;
    wovf_clr = clr;
    wq2_rptr = rptr;
    @(posedge wclk);
    #1;
  endtask

  task automatic doReset(input string tag);
    @(negedge wclk);
    wrst_n   = 1'b0;
    winc     = 1'b0;
    wovf_clr = 1'b0;
    wq2_rptr = '0;
    #1;
    checkOutput(tag, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] mb;

    // Fill sequence from empty, then overflow and read-advance vectors.
    for (int i = 1; i <= 16; i++) begin
      vecs[i-1] = '{1'b1, 1'b0, 5'd0, 4'(i), gray(5'(i)), (i == 16), (i >= 14), 5'(i), 1'b0};
    end
    vecs[16] = '{1'b1, 1'b0, 5'b00000, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 5'b00000, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 5'b00000, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 5'b00110, 4'd0, 5'b11000, 1'b0, 1'b0, 5'd12, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 5'b00110, 4'd0, 5'b11000, 1'b0, 1'b0, 5'd12, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 5'b00110, 4'd1, 5'b11001, 1'b0, 1'b0, 5'd13, 1'b0};

    wrst_n   = 1'b0;
    winc     = 1'b0;
    wovf_clr = 1'b0;
    wq2_rptr = '0;
    #2;
    checkOutput("por", 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    doReset("reset");

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].winc, vecs[i].clr, vecs[i].rptr);
      checkOutput($sformatf("vec%0d", i), vecs[i].waddr, vecs[i].wptr, vecs[i].full,
                  vecs[i].afull, vecs[i].level, vecs[i].ovf);
    end

    // Wrap: read pointer trails the write pointer by three entries.
    doReset("wrap_reset");
    mb = '0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0);
      mb = mb + 5'd1;
    end
    check("wrap_start.wlevel", 32'(wlevel), 32'd3);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, gray(mb - 5'd2));
      mb = mb + 5'd1;
      checkOutput($sformatf("wrap%0d", i), mb[3:0], gray(mb), 1'b0, 1'b0, 5'd3, 1'b0);
    end

    // Asynchronous reset between edges after five writes.
    doReset("mid_reset_pre");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 5'd0);
    check("mid_pre.waddr", 32'(waddr), 32'd5);
    #2;
    wrst_n = 1'b0;
    #1;
    checkOutput("mid_reset", 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd0);
    checkOutput("after_reset", 4'd1, 5'b00001, 1'b0, 1'b0, 5'd1, 1'b0);

    // Level 15 with a simultaneous write and read advance holds the level.
    doReset("lvl15_reset");
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 5'd0);
    checkOutput("lvl15", 4'd15, gray(5'd15), 1'b0, 1'b1, 5'd15, 1'b0);
    applyStimulus(1'b1, 1'b0, gray(5'd1));
    checkOutput("lvl15_both", 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b0);

    winc = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
